// File: rtl/prog_loader_if.sv
// Boot-loader bus: UART receive pin in, instruction-RAM write port and CPU
// control/status out.
interface prog_loader_if;
  logic        rx;
  logic [10:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic        cpuRun;
  logic        busy;
  logic        loadErr;

  modport master (
    input  rx,
    output waddr, wdata, wen, cpuRun, busy, loadErr
  );

  modport slave (
    output rx,
    input  waddr, wdata, wen, cpuRun, busy, loadErr
  );
endinterface

// File: rtl/prog_loader.sv
// UART-fed boot loader: receives a framed, checksummed program image and
// writes it word by word into instruction RAM, then releases the CPU.
module prog_loader #(
  parameter int CLKS_PER_BIT   = 139,
  parameter int AUTORUN_CYCLES = 16000000,
  parameter int TIMEOUT_CYCLES = 1600000
) (
  input logic          clk_i,
  input logic          rst_ni,
  prog_loader_if.master bus
);

  localparam int BaudW = $clog2(CLKS_PER_BIT + 1);
  localparam int AutoW = $clog2(AUTORUN_CYCLES + 1);
  localparam int IdleW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BaudW-1:0] BaudOne   = BaudW'(1);
  localparam logic [BaudW-1:0] BaudHalf  = BaudW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BaudW-1:0] BaudFull  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [AutoW-1:0] AutoLimit = AutoW'(AUTORUN_CYCLES);
  localparam logic [IdleW-1:0] IdleLimit = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       SyncByte  = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
  typedef enum logic [2:0] {
    L_WAIT, L_IDLE, L_CNT_HI, L_CNT_LO, L_DATA, L_SUM, L_RUN
  } ldState_e;

  logic             rxMeta_q, rxSync_q;
  rxState_e         rxState_q;
  logic [BaudW-1:0] baudCnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q, rxByte_q;
  logic             byteValid_q, frameErr_q;

  ldState_e         state_q;
  logic [10:0]      waddr_q;
  logic [31:0]      wdata_q;
  logic             wen_q, cpuRun_q, busy_q, loadErr_q;
  logic [7:0]       sum_q, cntHi_q;
  logic [11:0]      nWords_q, wordCnt_q;
  logic [1:0]       byteIdx_q;
  logic [AutoW-1:0] autoCnt_q;
  logic [IdleW-1:0] idleCnt_q;

  logic [15:0] countFull;
  logic        syncSeen, timedOut;

  assign countFull = {cntHi_q, rxByte_q};
  assign syncSeen  = byteValid_q && (rxByte_q == SyncByte);
  assign timedOut  = !byteValid_q && (idleCnt_q == IdleLimit);

  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.wen     = wen_q;
  assign bus.cpuRun  = cpuRun_q;
  assign bus.busy    = busy_q;
  assign bus.loadErr = loadErr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= bus.rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // The detection cycle counts as the first cycle of the start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxState_q   <= RX_IDLE;
      baudCnt_q   <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      rxByte_q    <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (!rxSync_q) begin
            rxState_q <= RX_START;
            baudCnt_q <= BaudOne;
          end
        end
        RX_START: begin
          if (baudCnt_q == BaudHalf) begin
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            baudCnt_q <= baudCnt_q + BaudOne;
          end
        end
        RX_DATA: begin
          if (baudCnt_q == BaudFull) begin
            baudCnt_q <= '0;
            shift_q   <= {rxSync_q, shift_q[7:1]};
            bitIdx_q  <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) rxState_q <= RX_STOP;
          end else begin
            baudCnt_q <= baudCnt_q + BaudOne;
          end
        end
        RX_STOP: begin
          if (baudCnt_q == BaudFull) begin
            baudCnt_q <= '0;
            rxState_q <= RX_IDLE;
            if (rxSync_q) begin
              byteValid_q <= 1'b1;
              rxByte_q    <= shift_q;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + BaudOne;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM; busy_q is set alongside every transition into or out of a frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= L_WAIT;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      cpuRun_q  <= 1'b0;
      busy_q    <= 1'b0;
      loadErr_q <= 1'b0;
      sum_q     <= '0;
      cntHi_q   <= '0;
      nWords_q  <= '0;
      wordCnt_q <= '0;
      byteIdx_q <= '0;
      autoCnt_q <= '0;
      idleCnt_q <= '0;
    end else begin
      wen_q <= 1'b0;
      if (wen_q && state_q == L_DATA) waddr_q <= waddr_q + 11'd1;

      if (!busy_q || byteValid_q) idleCnt_q <= '0;
      else                        idleCnt_q <= idleCnt_q + IdleW'(1);

      if (busy_q && (frameErr_q || timedOut)) begin
        state_q   <= L_IDLE;
        busy_q    <= 1'b0;
        loadErr_q <= 1'b1;
        cpuRun_q  <= 1'b0;
      end else begin
        case (state_q)
          L_WAIT: begin
            if (syncSeen) begin
              state_q   <= L_CNT_HI;
              busy_q    <= 1'b1;
              loadErr_q <= 1'b0;
            end else if (autoCnt_q == AutoLimit) begin
              state_q  <= L_RUN;
              cpuRun_q <= 1'b1;
            end else begin
              autoCnt_q <= autoCnt_q + AutoW'(1);
            end
          end
          L_IDLE, L_RUN: begin
            if (syncSeen) begin
              state_q   <= L_CNT_HI;
              busy_q    <= 1'b1;
              loadErr_q <= 1'b0;
              cpuRun_q  <= 1'b0;
            end
          end
          L_CNT_HI: begin
            if (byteValid_q) begin
              cntHi_q <= rxByte_q;
              state_q <= L_CNT_LO;
            end
          end
          L_CNT_LO: begin
            if (byteValid_q) begin
              if (countFull == 16'd0 || countFull > 16'd2048) begin
                state_q   <= L_IDLE;
                busy_q    <= 1'b0;
                loadErr_q <= 1'b1;
              end else begin
                nWords_q  <= countFull[11:0];
                waddr_q   <= '0;
                sum_q     <= '0;
                wordCnt_q <= '0;
                byteIdx_q <= '0;
                state_q   <= L_DATA;
              end
            end
          end
          L_DATA: begin
            if (byteValid_q) begin
              wdata_q   <= {wdata_q[23:0], rxByte_q};
              sum_q     <= sum_q + rxByte_q;
              byteIdx_q <= byteIdx_q + 2'd1;
              if (byteIdx_q == 2'd3) begin
                wen_q     <= 1'b1;
                wordCnt_q <= wordCnt_q + 12'd1;
                if (wordCnt_q == nWords_q - 12'd1) state_q <= L_SUM;
              end
            end
          end
          L_SUM: begin
            if (byteValid_q) begin
              busy_q <= 1'b0;
              if (rxByte_q == sum_q) begin
                state_q  <= L_RUN;
                cpuRun_q <= 1'b1;
              end else begin
                state_q   <= L_IDLE;
                loadErr_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= L_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the CPU core's 2048×32 instruction RAM. Receives a framed program image over a UART RX pin (8N1), assembles big-endian 32-bit words, and writes them into instruction RAM through a single write port. Holds the CPU in its run-inhibit state while loading. Releases the CPU only after a checksum-verified load, or after an autorun timeout when no host is present.

## Interface
- `CLKS_PER_BIT`, 139 — clock cycles per UART bit (16 MHz / 115200).
- `AUTORUN_CYCLES`, 16000000 — cycles after reset with no sync byte before `CPU_RUN` asserts using the existing RAM contents.
- `TIMEOUT_CYCLES`, 1600000 — maximum idle gap between bytes inside a frame before the load is aborted.
- `CLK` in 1 — system clock; all logic on its rising edge.
- `RST_N` in 1 — asynchronous, active-low reset.
- `RX` in 1 — UART serial input; idle high; asynchronous to `CLK`.
- `WADDR` out 11 — instruction RAM word address.
- `WDATA` out 32 — instruction RAM write data.
- `WEN` out 1 — one-cycle write strobe; `WADDR`/`WDATA` are valid when it is high.
- `CPU_RUN` out 1 — high lets the CPU execute; low holds it at pc=0, phase 0.
- `BUSY` out 1 — high while a frame is in progress.
- `LOAD_ERR` out 1 — sticky; set on any failed frame.

## Operation
- Reset values: `WADDR`=0, `WDATA`=0, `WEN`=0, `CPU_RUN`=0, `BUSY`=0, `LOAD_ERR`=0. Loader state is L_WAIT, autorun counter is 0, and the UART is in RX_IDLE.
- `RX` passes through a 2-flop synchroniser; the UART samples only the synchronised value.
- UART states:
  - RX_IDLE: on a synchronised 0, go to RX_START.
  - RX_START: at `CLKS_PER_BIT`/2, re-check. If the line is 1, treat it as a glitch and return to RX_IDLE. Otherwise go to RX_DATA.
  - RX_DATA: sample 8 bits, LSB first, every `CLKS_PER_BIT`.
  - RX_STOP: if the stop bit is 1, emit a one-cycle `byte_valid` with the byte. If the stop bit is 0, signal a framing error. In both cases return to RX_IDLE.
- Frame format: sync 0xA5; count hi; count lo (N words); 4·N data bytes, MSB first per word; checksum = low 8 bits of the sum of all 4·N data bytes.
- Loader states:
  - L_WAIT: counts cycles.
    - Byte 0xA5: go to L_CNT_HI.
    - Counter reaches `AUTORUN_CYCLES`: go to L_RUN.
    - Any other byte: ignore.
  - L_IDLE: only 0xA5 is accepted (→L_CNT_HI); all other bytes are ignored.
  - L_CNT_HI → L_CNT_LO: latch N.
    - If N=0 or N>2048, set `LOAD_ERR` and go to L_IDLE.
    - Otherwise clear the address and sum registers and go to L_DATA.
  - L_DATA: shift each byte into `WDATA` and add it to the 8-bit sum.
    - On the 4th byte of a word, pulse `WEN` with the current `WADDR`.
    - `WADDR` increments the cycle after `WEN`.
    - After word N, go to L_SUM.
  - L_SUM: if the received byte equals the sum, go to L_RUN; otherwise set `LOAD_ERR` and go to L_IDLE.
  - L_RUN: `CPU_RUN`=1. Byte 0xA5 drops `CPU_RUN` in the same cycle it is accepted and goes to L_CNT_HI for a reload; all other bytes are ignored.
- Accepting a sync byte clears `LOAD_ERR`.
- `BUSY`=1 in L_CNT_HI, L_CNT_LO, L_DATA and L_SUM only.
- Abort conditions while `BUSY`: a UART framing error, or `TIMEOUT_CYCLES` with no `byte_valid`. Either one sets `LOAD_ERR`, goes to L_IDLE, and leaves `CPU_RUN`=0.
- Words already written by an aborted frame remain in RAM. No rollback.
- `WADDR` wraps never: N≤2048 guarantees a maximum address of 2047.

## Timing
- Byte latency: `byte_valid` occurs ≤ 2 + 9.5·`CLKS_PER_BIT` cycles after the falling edge of the start bit.
- `WEN` is high exactly one cycle: the cycle after `byte_valid` of the word's 4th byte.
- `CPU_RUN` rises one cycle after `byte_valid` of a correct checksum.
- In L_RUN, `CPU_RUN` falls one cycle after `byte_valid` of 0xA5.
- Autorun: `CPU_RUN` rises exactly `AUTORUN_CYCLES`+1 cycles after `RST_N` deasserts, provided no sync byte arrived.
- A sync byte and autorun expiry in the same cycle: the sync byte wins.
- `RST_N` asserted mid-frame: all outputs immediately take their reset values, including `CPU_RUN`=0, and the partial frame is discarded.
- `WEN` and state changes never depend on `RX` combinationally.

## Test plan
- Use `CLKS_PER_BIT`=16, `AUTORUN_CYCLES`=5000, `TIMEOUT_CYCLES`=2000 for all scenarios.
- Valid load: send A5 00 02 20 00 00 01 10 00 FF FF, checksum 0x2F → `WEN` pulses at `WADDR` 0 with `WDATA` 0x20000001 and at `WADDR` 1 with `WDATA` 0x1000FFFF; `CPU_RUN` rises; `LOAD_ERR`=0.
- Bad checksum: same frame with checksum 0x30 → both `WEN` pulses occur; `LOAD_ERR`=1; `CPU_RUN` stays 0; a following valid frame clears `LOAD_ERR` and asserts `CPU_RUN`.
- Count bounds: A5 00 00, and separately A5 08 01 → `LOAD_ERR`=1, no `WEN`, `BUSY` returns to 0.
- Autorun and glitch: idle `RX` except a 4-cycle low glitch → no byte received; `CPU_RUN` rises at cycle 5001 after reset release.
- Abort: mid-data, a stop bit of 0 in one run, and a 2000-cycle silence in another → `LOAD_ERR`=1; `CPU_RUN`=0; `BUSY` falls.
- Reload and reset: in L_RUN send A5 → `CPU_RUN` falls one cycle after the byte; pull `RST_N` low mid-frame → all outputs reset asynchronously.
